// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared CPU bus widths, write-entry struct, phi2 filter states and window decode
package cpu_bus_pkg;
  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 8;
  typedef struct packed {
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] data;
  } cpu_wr_t;
  typedef enum logic {PHI2_LOW, PHI2_HIGH} phi2_state_e;
  function automatic logic addr_hit(input logic [CPU_ADDR_W-1:0] a, base, mask);
    return (a & mask) == (base & mask);
  endfunction
endpackage

// File: rtl/cpu_write_capture_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO
//   clk_i/rst_i  clock, synchronous active-high reset
//   push_i/din_i write side; accepted when not full, or when full with a pop in the same cycle
//   pop_i        consume head; ignored when empty
//   dout_o       head entry, zero while empty
//   full_o/empty_o/count_o occupancy
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    dout_o = empty_o ? '0 : mem_q[rd_q];
    count_o = cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/cpu_write_capture.sv
// cpu_write_capture: glitch-filter phi2 and queue CPU writes that hit an address window
//   clk_96mhz/reset        clock, synchronous active-high reset
//   i_cpu_addr/data/phi2/rw synchronised CPU bus (rw 0 = write)
//   o_wr_valid/i_wr_ready  FWFT pop handshake; o_wr_addr/o_wr_data show the head
//   o_fifo_count           occupancy
//   o_overflow/i_overflow_clr sticky drop flag and its clear (set wins)
module cpu_write_capture
  import cpu_bus_pkg::*;
#(
  parameter logic [CPU_ADDR_W-1:0] BASE_ADDR = 16'hFE00,
  parameter logic [CPU_ADDR_W-1:0] ADDR_MASK = 16'hFF00,
  parameter int FIFO_DEPTH = 8,
  parameter int PHI2_FILTER = 3
) (
  input  logic                          clk_96mhz,
  input  logic                          reset,
  input  logic [CPU_ADDR_W-1:0]         i_cpu_addr,
  input  logic [CPU_DATA_W-1:0]         i_cpu_data,
  input  logic                          i_cpu_phi2,
  input  logic                          i_cpu_rw,
  output logic                          o_wr_valid,
  input  logic                          i_wr_ready,
  output logic [CPU_ADDR_W-1:0]         o_wr_addr,
  output logic [CPU_DATA_W-1:0]         o_wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow,
  input  logic                          i_overflow_clr
);
  phi2_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [CPU_ADDR_W-1:0] addr_q;
  logic [CPU_DATA_W-1:0] data_q;
  logic rw_q, disagree, trip, fall, push_q, push_d, ovf_q, ovf_d, pop, full, empty;
  cpu_wr_t entry_q, head;
  // the counter only runs while raw phi2 disagrees with the filtered level
  always_comb begin
    disagree = (state_q == PHI2_LOW) ? i_cpu_phi2 : !i_cpu_phi2;
    cnt_inc = cnt_q + 4'd1;
    trip = disagree && cnt_inc == 4'(PHI2_FILTER);
    cnt_d = (disagree && !trip) ? cnt_inc : 4'd0;
    state_d = !trip ? state_q : (state_q == PHI2_LOW) ? PHI2_HIGH : PHI2_LOW;
  end
  always_ff @(posedge clk_96mhz) begin
    if (reset) begin
      state_q <= PHI2_LOW;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // the commit is registered so the FIFO write lands one edge after the filter falls
  always_comb begin
    fall = trip && state_q == PHI2_HIGH;
    push_d = fall && !rw_q && addr_hit(addr_q, BASE_ADDR, ADDR_MASK);
    pop = o_wr_valid && i_wr_ready;
    ovf_d = (push_q && full && !pop) ? 1'b1 : i_overflow_clr ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk_96mhz) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      rw_q <= 1'b0;
      push_q <= 1'b0;
      entry_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (i_cpu_phi2) begin
        addr_q <= i_cpu_addr;
        data_q <= i_cpu_data;
        rw_q <= i_cpu_rw;
      end
      if (fall) entry_q <= '{addr: addr_q, data: data_q};
      push_q <= push_d;
      ovf_q <= ovf_d;
    end
  end
  sync_fifo #(.WIDTH($bits(cpu_wr_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_96mhz),
    .rst_i(reset),
    .push_i(push_q),
    .din_i(entry_q),
    .pop_i(pop),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(o_fifo_count)
  );
  assign o_wr_valid = !empty;
  assign o_wr_addr = head.addr;
  assign o_wr_data = head.data;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_cpu_write_capture.sv
// tb_cpu_write_capture: randomized and directed checks of cpu_write_capture against a queue model
module tb_cpu_write_capture;
  localparam int FILT = 3;
  localparam int DEPTH = 8;
  logic clk_96mhz = 1'b0;
  logic reset = 1'b1;
  logic [15:0] i_cpu_addr = '0;
  logic [7:0] i_cpu_data = '0;
  logic i_cpu_phi2 = 1'b0, i_cpu_rw = 1'b1, i_wr_ready = 1'b0, i_overflow_clr = 1'b0;
  logic o_wr_valid, o_overflow;
  logic [15:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic [3:0] o_fifo_count;
  int tests = 0, fails = 0;
  logic [23:0] mq[$];
  logic m_ovf;

  always #5 clk_96mhz = ~clk_96mhz;

  cpu_write_capture #(.BASE_ADDR(16'hFE00), .ADDR_MASK(16'hFF00), .FIFO_DEPTH(DEPTH), .PHI2_FILTER(FILT)) dut (
    .clk_96mhz(clk_96mhz), .reset(reset), .i_cpu_addr(i_cpu_addr), .i_cpu_data(i_cpu_data),
    .i_cpu_phi2(i_cpu_phi2), .i_cpu_rw(i_cpu_rw), .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_fifo_count(o_fifo_count),
    .o_overflow(o_overflow), .i_overflow_clr(i_overflow_clr)
  );

  task automatic tick();
    @(posedge clk_96mhz);
    @(negedge clk_96mhz);
  endtask

  task automatic do_reset();
    reset = 1'b1; i_cpu_phi2 = 1'b0; i_wr_ready = 1'b0; i_overflow_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    mq.delete(); m_ovf = 1'b0;
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] d, input logic rw);
    if (!rw && a[15:8] == 8'hFE) begin
      if (mq.size() < DEPTH) mq.push_back({a, d});
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    i_cpu_addr = a; i_cpu_data = d; i_cpu_rw = rw; i_cpu_phi2 = 1'b1;
    repeat (20) tick();
    i_cpu_phi2 = 1'b0;
    repeat (FILT + 3) tick();
    model(a, d, rw);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (o_wr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_wr_valid); end
    tests++; if (o_fifo_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", o_fifo_count); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
    tests++; if ({o_wr_addr, o_wr_data} !== 24'h0) begin fails++; $display("FAIL reset_head: got %h want 000000", {o_wr_addr, o_wr_data}); end
  endtask

  task automatic test_single_write();
    int n;
    do_reset();
    i_cpu_addr = 16'hFE12; i_cpu_data = 8'hA5; i_cpu_rw = 1'b0; i_cpu_phi2 = 1'b1;
    repeat (40) tick();
    i_cpu_phi2 = 1'b0;
    n = 0;
    while (!o_wr_valid && n < 20) begin tick(); n++; end
    tests++; if (n != FILT + 1) begin fails++; $display("FAIL single_latency: got %0d cycles want %0d", n, FILT + 1); end
    tests++; if ({o_wr_addr, o_wr_data} !== 24'hFE12A5) begin fails++; $display("FAIL single_head: got %h want fe12a5", {o_wr_addr, o_wr_data}); end
    tests++; if (o_fifo_count !== 4'd1) begin fails++; $display("FAIL single_count: got %0d want 1", o_fifo_count); end
    i_wr_ready = 1'b1; tick(); i_wr_ready = 1'b0;
    tests++; if (o_wr_valid !== 1'b0) begin fails++; $display("FAIL single_pop: got valid %b want 0", o_wr_valid); end
  endtask

  task automatic test_glitch();
    do_reset();
    i_cpu_addr = 16'hFE12; i_cpu_data = 8'h11; i_cpu_rw = 1'b0; i_cpu_phi2 = 1'b1;
    repeat (20) tick();
    i_cpu_phi2 = 1'b0;
    repeat (FILT - 1) tick();
    i_cpu_phi2 = 1'b1; i_cpu_data = 8'h3C;
    repeat (20) tick();
    tests++; if (o_fifo_count !== 4'd0) begin fails++; $display("FAIL glitch_none: got count %0d want 0", o_fifo_count); end
    i_cpu_phi2 = 1'b0;
    repeat (FILT + 3) tick();
    tests++; if (o_fifo_count !== 4'd1) begin fails++; $display("FAIL glitch_count: got %0d want 1", o_fifo_count); end
    tests++; if ({o_wr_addr, o_wr_data} !== 24'hFE123C) begin fails++; $display("FAIL glitch_head: got %h want fe123c", {o_wr_addr, o_wr_data}); end
  endtask

  task automatic test_decode();
    do_reset();
    cpu_cycle(16'hFE12, 8'h77, 1'b1);
    tests++; if (o_fifo_count !== 4'd0) begin fails++; $display("FAIL decode_read: got count %0d want 0", o_fifo_count); end
    cpu_cycle(16'hFD12, 8'h66, 1'b0);
    tests++; if (o_wr_valid !== 1'b0) begin fails++; $display("FAIL decode_miss: got valid %b want 0", o_wr_valid); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0] d;
    logic rw;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      a = $urandom_range(0, 1) ? {8'hFE, 8'($urandom)} : 16'($urandom);
      d = 8'($urandom);
      rw = ($urandom_range(0, 3) == 0);
      i_cpu_addr = a; i_cpu_data = d; i_cpu_rw = rw; i_cpu_phi2 = 1'b1;
      for (int c = 0; c < 12; c++) begin
        i_wr_ready = ($urandom_range(0, 3) == 0);
        tests++; if (o_wr_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rand_valid: got %b want %b", o_wr_valid, mq.size() != 0); end
        if (mq.size() != 0) begin
          tests++; if ({o_wr_addr, o_wr_data} !== mq[0]) begin fails++; $display("FAIL rand_head: got %h want %h", {o_wr_addr, o_wr_data}, mq[0]); end
        end
        tick();
        if (i_wr_ready && mq.size() != 0) void'(mq.pop_front());
      end
      i_wr_ready = 1'b0; i_cpu_phi2 = 1'b0;
      repeat (FILT + 3) tick();
      model(a, d, rw);
    end
    tests++; if (o_fifo_count !== 4'(mq.size())) begin fails++; $display("FAIL rand_count: got %0d want %0d", o_fifo_count, mq.size()); end
    tests++; if (o_overflow !== m_ovf) begin fails++; $display("FAIL rand_ovf: got %b want %b", o_overflow, m_ovf); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) cpu_cycle(16'hFE00 + 16'(i), 8'(i * 17), 1'b0);
    tests++; if (o_fifo_count !== 4'd8) begin fails++; $display("FAIL ovf_count: got %0d want 8", o_fifo_count); end
    tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
    i_wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (!o_wr_valid || {o_wr_addr, o_wr_data} !== {16'hFE00 + 16'(i), 8'(i * 17)}) begin
        fails++; $display("FAIL ovf_pop%0d: got v=%b %h want %h", i, o_wr_valid, {o_wr_addr, o_wr_data}, {16'hFE00 + 16'(i), 8'(i * 17)});
      end
      tick();
    end
    i_wr_ready = 1'b0;
    tests++; if (o_wr_valid !== 1'b0) begin fails++; $display("FAIL ovf_ninth: got valid %b want 0", o_wr_valid); end
  endtask

  task automatic full_then_commit(input logic [7:0] d, input logic use_pop, input logic use_clr);
    i_cpu_addr = 16'hFE99; i_cpu_data = d; i_cpu_rw = 1'b0; i_cpu_phi2 = 1'b1;
    repeat (20) tick();
    i_cpu_phi2 = 1'b0;
    repeat (FILT) tick();
    i_wr_ready = use_pop; i_overflow_clr = use_clr;
    tick();
    i_wr_ready = 1'b0; i_overflow_clr = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) cpu_cycle(16'hFE20 + 16'(i), 8'(i + 1), 1'b0);
    full_then_commit(8'hEE, 1'b1, 1'b0);
    tests++; if (o_fifo_count !== 4'd8) begin fails++; $display("FAIL fpp_count: got %0d want 8", o_fifo_count); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL fpp_ovf: got %b want 0", o_overflow); end
    i_wr_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      logic [23:0] e;
      e = (i == 8) ? 24'hFE99EE : {16'hFE20 + 16'(i), 8'(i + 1)};
      tests++; if ({o_wr_addr, o_wr_data} !== e) begin fails++; $display("FAIL fpp_pop%0d: got %h want %h", i, {o_wr_addr, o_wr_data}, e); end
      tick();
    end
    i_wr_ready = 1'b0;
  endtask

  task automatic test_ovf_clear_race();
    do_reset();
    for (int i = 0; i < 8; i++) cpu_cycle(16'hFE40 + 16'(i), 8'(i), 1'b0);
    full_then_commit(8'h55, 1'b0, 1'b1);
    tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL race_set: got %b want 1", o_overflow); end
    i_overflow_clr = 1'b1; tick(); i_overflow_clr = 1'b0;
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL race_clr: got %b want 0", o_overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cpu_cycle(16'hFE60 + 16'(i), 8'(i), 1'b0);
    tests++; if (o_fifo_count !== 4'd3) begin fails++; $display("FAIL rmid_pre: got %0d want 3", o_fifo_count); end
    i_cpu_addr = 16'hFE12; i_cpu_data = 8'h5A; i_cpu_rw = 1'b0; i_cpu_phi2 = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if (o_fifo_count !== 4'd0 || o_wr_valid !== 1'b0) begin fails++; $display("FAIL rmid_flush: got count %0d valid %b want 0 0", o_fifo_count, o_wr_valid); end
    repeat (FILT - 1) tick();
    i_cpu_phi2 = 1'b0;
    repeat (FILT + 3) tick();
    tests++; if (o_fifo_count !== 4'd0) begin fails++; $display("FAIL rmid_nocommit: got count %0d want 0", o_fifo_count); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_glitch();
    test_decode();
    test_random();
    test_overflow();
    test_full_push_pop();
    test_ovf_clear_race();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_write_capture.md
# cpu_write_capture

Consumes the registered, two-stage-synchronised CPU address/data bus in the clk_96mhz domain together with synchronised phi2 and R/W strobes, and turns each completed CPU write cycle that hits a configured address window into one entry in a small FIFO. It sits directly downstream of the bus input cleaner and upstream of the register-file/peripheral logic, which pops captured writes through a valid/ready handshake. Phi2 is glitch-filtered so that ringing on the bus cannot create spurious or duplicate captures.

## Interface
- BASE_ADDR, 16'hFE00, window base; an address matches when (addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)
- ADDR_MASK, 16'hFF00, window mask
- FIFO_DEPTH, 8, entry count; power of two, 2..64
- PHI2_FILTER, 3, consecutive cycles phi2 must disagree with its filtered value before the filtered value flips; 1..15
- clk_96mhz  input  1  single clock for all logic
- reset  input  1  synchronous, active-high reset
- i_cpu_addr  input  16  synchronised CPU address
- i_cpu_data  input  8  synchronised CPU data
- i_cpu_phi2  input  1  synchronised, unfiltered phi2
- i_cpu_rw  input  1  synchronised R/W; 0 = write
- o_wr_valid  output  1  FIFO head holds a captured write
- i_wr_ready  input  1  consumer accepts the head this cycle
- o_wr_addr  output  16  captured address at the FIFO head
- o_wr_data  output  8  captured data at the FIFO head
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
- o_overflow  output  1  sticky: a matching write was dropped because the FIFO was full
- i_overflow_clr  input  1  clears o_overflow

## Operation
- The phi2 filter has 2 states, LOW and HIGH, plus a counter of width 4.
  - In LOW: the counter increments while i_cpu_phi2=1 and clears when i_cpu_phi2=0. When the counter reaches PHI2_FILTER, go to HIGH and clear the counter.
  - HIGH is symmetric, with i_cpu_phi2=0 as the trigger, and goes to LOW.
- Shadow registers hold addr, data and rw. They load i_cpu_addr, i_cpu_data and i_cpu_rw on every cycle where raw i_cpu_phi2=1, and hold otherwise. The shadow therefore holds the last bus values seen while phi2 was high.
- Commit: the HIGH→LOW transition of the filter commits the shadow values. A commit pushes {addr,data} when shadow rw=0 and the address matches the window. Reads and non-matching writes are ignored.
- FIFO ordering and visibility:
  - The FIFO is first-word-fall-through. o_wr_addr and o_wr_data reflect the head whenever o_wr_valid=1.
  - o_wr_valid = (count != 0).
  - A pop occurs on o_wr_valid & i_wr_ready.
- Full FIFO:
  - A push when count==FIFO_DEPTH with no pop in the same cycle is dropped and sets o_overflow.
  - A push when full with a simultaneous pop is accepted, and count stays at FIFO_DEPTH.
- Simultaneous push and pop when not full leaves count unchanged and preserves order.
- i_overflow_clr in the same cycle as a new overflow event: set wins.
- Pointers wrap modulo FIFO_DEPTH. Count is one bit wider than the pointers so full and empty are distinct.
- Reset values:
  - Filter state LOW, counter 0, shadow 0.
  - FIFO empty, pointers 0, o_fifo_count 0.
  - o_wr_valid 0, o_overflow 0.
  - o_wr_addr and o_wr_data are 0.
- Reset mid-operation: all pending entries are discarded. After reset, a filtered LOW→HIGH transition must occur before any commit is possible.

## Timing
- Let edge E be the first clk_96mhz edge at which i_cpu_phi2=0 is sampled after a stable high.
  - The filter enters LOW at edge E+PHI2_FILTER-1.
  - The push is written on the next edge, and o_wr_valid rises after it.
  - Total latency: PHI2_FILTER+1 cycles from E to o_wr_valid.
- A phi2 low pulse shorter than PHI2_FILTER cycles causes no commit, and the shadow keeps updating.
- Pop takes effect at the clock edge. The next head is visible on the following cycle, so back-to-back pops give one entry per cycle.
- Bus-rate budget: a 1–2 MHz CPU cycle is at least 48 clk_96mhz cycles. At most one commit per CPU cycle, so FIFO_DEPTH absorbs consumer stalls only.

## Structure
- Shared package cpu_bus_pkg holds:
  - CPU_ADDR_W=16 and CPU_DATA_W=8.
  - A packed struct cpu_wr_t {addr, data} used as the FIFO entry and reused by downstream consumers.
  - An enum for the filter states.
- One sub-module, sync_fifo, is parameterised on width and depth. It is a single-clock FWFT FIFO with push/pop/full/empty/count and synchronous active-high reset.
- The filter, shadow, window match and overflow flag live in the top level.

## Test plan
- Single write: phi2 high for 40 cycles with addr 16'hFE12, data 8'hA5, rw=0, then phi2 low → one entry {FE12,A5}, o_wr_valid rises exactly PHI2_FILTER+1 cycles after phi2 low is first sampled.
- Filtering and decode:
  - Phi2 low glitch of PHI2_FILTER-1 cycles mid-write → no entry.
  - A read (rw=1) at FE12 → no entry.
  - A write to 16'hFD12 → no entry.
- Overflow: i_wr_ready=0, 9 matching writes with FIFO_DEPTH=8 → count 8, o_overflow=1, 8 entries pop in order, the 9th is absent.
- Full with simultaneous push/pop: FIFO full, commit in the same cycle as a pop → count stays 8, no overflow, new entry is last out.
- Overflow clear race: i_overflow_clr asserted in the same cycle a new drop occurs → o_overflow remains 1. A later clear alone → o_overflow 0.
- Reset mid-operation: 3 entries queued, reset pulsed 1 cycle → count 0, o_wr_valid 0. A phi2 fall before any post-reset rise → no entry.
